// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encodings and clock-edge selection.
package spi_pkg;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACTIVE = 1'b1;

   // 1: sample on sck rising edge, shift on falling; 0: the other way round.
   function automatic logic spi_sample_rise(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with rise/fall detect; edges appear 2 clk after the pin and act on the 3rd.
module spi_sync #(
   parameter logic P_RST = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= P_RST;
         r_sync <= P_RST;
         r_prev <= P_RST;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI slave, all CPOL/CPHA modes, 1..32-bit words, AXI-Stream on both sides.
// Pin-to-action 3 clk; one-word TX holding register; RX word kept and new one dropped on overrun.
module spi_slave
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpol,
   input  logic        cpha,
   input  logic [5:0]  width,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        overrun,
   output logic        underrun
);

   logic        w_cs_rise, w_cs_fall, w_unused_cs_lvl;
   logic        w_sck_rise, w_sck_fall, w_unused_sck_lvl;
   logic        w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

   logic        r_state, w_state_nxt, w_active;
   logic [4:0]  r_bit_cnt;
   logic [30:0] r_rx_sh;
   logic [31:0] r_tx_sh, r_hold_dat, r_m_dat;
   logic        r_hold_vld, r_tx_pend, r_m_vld, r_overrun, r_underrun;

   logic [5:0]  w_w;
   logic [4:0]  w_last;
   logic [31:0] w_mask, w_rx_word;
   logic        w_samp_rise, w_enter, w_abort, w_sample, w_shift, w_load, w_wrap, w_s_fire;

   spi_sync #(.P_RST(1'b1)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .i_async(cs),
      .o_sync(w_unused_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_sync #(.P_RST(1'b0)) u_sck_sync (
      .clk(clk), .rst_n(rst_n), .i_async(sck),
      .o_sync(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   spi_sync #(.P_RST(1'b0)) u_mosi_sync (
      .clk(clk), .rst_n(rst_n), .i_async(mosi),
      .o_sync(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_cs_fall) w_state_nxt = ST_ACTIVE;
         default: if (w_cs_rise) w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_active = (r_state == ST_ACTIVE);
   end

   // Width 0 (and anything out of range) means a full 32-bit word.
   assign w_w         = (width == 6'd0 || width > 6'd32) ? 6'd32 : width;
   assign w_last      = w_w[4:0] - 5'd1;
   assign w_mask      = 32'hFFFF_FFFF >> (6'd32 - w_w);
   assign w_samp_rise = spi_sample_rise(cpol, cpha);

   assign w_enter  = ~w_active & w_cs_fall;
   assign w_abort  = w_active & w_cs_rise;
   assign w_sample = w_active & ~w_cs_rise & (w_samp_rise ? w_sck_rise : w_sck_fall);
   assign w_shift  = w_active & ~w_cs_rise & (w_samp_rise ? w_sck_fall : w_sck_rise);
   assign w_load   = (w_enter & ~cpha) | (w_shift & (r_bit_cnt == 5'd0));
   assign w_wrap   = w_sample & (r_bit_cnt == w_last);
   assign w_s_fire = s_axis_tvalid & ~r_hold_vld;
   assign w_rx_word = {r_rx_sh, w_mosi} & w_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_bit_cnt <= 5'd0;
      else if (w_enter | w_abort) r_bit_cnt <= 5'd0;
      else if (w_sample)          r_bit_cnt <= w_wrap ? 5'd0 : r_bit_cnt + 5'd1;
   end

   // The holding word stays claimed until its first bit is actually sampled by the master.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_vld <= 1'b0;
         r_hold_dat <= 32'd0;
         r_tx_pend  <= 1'b0;
         r_tx_sh    <= 32'd0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         if (w_s_fire) begin
            r_hold_vld <= 1'b1;
            r_hold_dat <= s_axis_tdata;
         end else if (w_sample & r_tx_pend) begin
            r_hold_vld <= 1'b0;
         end
         if (w_abort)       r_tx_pend <= 1'b0;
         else if (w_load)   r_tx_pend <= r_hold_vld;
         else if (w_sample) r_tx_pend <= 1'b0;
         if (w_abort) begin
            r_tx_sh <= 32'd0;
         end else if (w_load) begin
            r_tx_sh    <= r_hold_vld ? r_hold_dat : 32'd0;
            r_underrun <= ~r_hold_vld;
         end else if (w_shift) begin
            r_tx_sh <= {r_tx_sh[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_sh   <= 31'd0;
         r_m_dat   <= 32'd0;
         r_m_vld   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_enter)       r_rx_sh <= 31'd0;
         else if (w_sample) r_rx_sh <= {r_rx_sh[29:0], w_mosi};
         if (w_wrap) begin
            if (r_m_vld & ~m_axis_tready) begin
               r_overrun <= 1'b1;
            end else begin
               r_m_dat <= w_rx_word;
               r_m_vld <= 1'b1;
            end
         end else if (r_m_vld & m_axis_tready) begin
            r_m_vld <= 1'b0;
         end
      end
   end

   assign miso          = w_active & r_tx_sh[w_last];
   assign s_axis_tready = ~r_hold_vld;
   assign m_axis_tdata  = r_m_dat;
   assign m_axis_tvalid = r_m_vld;
   assign overrun       = r_overrun;
   assign underrun      = r_underrun;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint: the far end of the link driven by the team's SPI master blocks. It receives MOSI bits into AXI-Stream words on `m_axis_*` and transmits words taken from `s_axis_*` on MISO, full duplex, MSB first. All four CPOL/CPHA modes are supported and word width is configurable from 1 to 32 bits. The SPI pins are oversampled in the `clk` domain; no logic runs on `sck`.

## Interface
- Parameters: none. Mode and width are run-time inputs.
- `clk`  in  1  system clock; must be ≥ 8× the sck frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpol`  in  1  sck idle level.
- `cpha`  in  1  0: sample on odd edges; 1: sample on even edges.
- `width`  in  6  bits per word, 1..32; 0 is treated as 32. Change only while `cs` is high.
- `cs`  in  1  chip select, active low, asynchronous.
- `sck`  in  1  SPI clock, asynchronous.
- `mosi`  in  1  serial data in.
- `miso`  out  1  serial data out.
- `s_axis_tdata`  in  32  next TX word, right-aligned (bits `width-1:0` used).
- `s_axis_tvalid`  in  1  TX word valid.
- `s_axis_tready`  out  1  TX holding register empty.
- `m_axis_tdata`  out  32  received word, right-aligned, upper bits 0.
- `m_axis_tvalid`  out  1  RX word valid.
- `m_axis_tready`  in  1  downstream accept.
- `overrun`  out  1  one-cycle pulse: RX word lost.
- `underrun`  out  1  one-cycle pulse: TX word needed while holding register empty.

## Operation
- `cs`, `sck` and `mosi` each pass through a 2-FF synchronizer. Edges of `cs` and `sck` are detected on the synchronized signals.
- Edge select: `cpol^cpha==0` samples on the sck rising edge and shifts on the falling edge; otherwise the edges are swapped.
- FSM states: IDLE and ACTIVE.
  - IDLE→ACTIVE on a cs falling edge.
  - ACTIVE→IDLE on a cs rising edge, from any bit position.
- Bit counter `bit_cnt` runs 0..width-1.
  - It is cleared on entry to ACTIVE.
  - It increments on each sample edge and wraps to 0 after `width-1`, so multiple words per frame are supported.
- RX path:
  - On each sample edge, shift the synchronized `mosi` into `rx_sh`.
  - On the wrap sample edge, copy the completed word to `m_axis_tdata` and set `m_axis_tvalid`.
  - If `m_axis_tvalid` is still high without `m_axis_tready` at that moment: keep the old word, drop the new one, and pulse `overrun`.
- TX load points:
  - cpha=0: at the cs falling edge, and at each shift edge with `bit_cnt==0`.
  - cpha=1: at each shift edge with `bit_cnt==0`.
- Load source: the holding register, or all-zeros plus an `underrun` pulse if the holding register is empty.
- Holding register release: it is released (`s_axis_tready` rises) on the first sample edge of the word it supplied. A cpha=0 trailing load with no following sample edge therefore does not consume the word.
- At non-load shift edges, `tx_sh` shifts left.
- `miso` = `tx_sh[width-1]` while ACTIVE, and 0 in IDLE.
- `s_axis` handshake: a transfer occurs when `tvalid && tready`. The holding register is one word deep. `s_axis_tready = !hold_valid`.
- cs rising mid-word: discard the partial RX word, no `m_axis_tvalid`; clear `tx_sh`; keep the holding register unless its word was already released.

## Timing
- Reset values: `miso`=0, `m_axis_tdata`=0, `m_axis_tvalid`=0, `s_axis_tready`=1, `overrun`=0, `underrun`=0, state IDLE, `bit_cnt`=0.
- Pin-to-action latency is 3 clk: 2 synchronizer stages plus 1 edge-detect register.
- `miso` changes 3 clk after the shift edge; with clk ≥ 8× sck this holds ≥1 clk of margin before the next sample edge.
- `m_axis_tvalid` rises 3 clk after the sck edge that samples the last bit of a word.
- `m_axis_tvalid` clears in the cycle after `tvalid && tready`.
- `m_axis_tdata` is stable while `m_axis_tvalid` is high.
- If a word completes in the same cycle as `m_axis_tready` is accepted: the new word is loaded and `tvalid` stays high, with no overrun.
- If an `s_axis` write coincides with a release: the holding register takes the new word and `tready` stays 0.
- Reset asserted mid-frame forces all reset values immediately.

## Structure
- `spi_pkg`: FSM state localparams (IDLE, ACTIVE) and a function `spi_sample_rise(cpol,cpha)` returning the edge select.
- Sub-module `spi_sync`: 2-FF synchronizer plus rise/fall edge detect.
  - Instantiated for `cs`, `sck` and `mosi`; the `mosi` instance uses the data output only.
- Everything else lives in `spi_slave`.

## Test plan
- Mode 0, width=8, TX word 0xA5 preloaded, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; `m_axis_tdata`=0x0000003C; `m_axis_tvalid` rises 3 clk after the 8th rising edge.
- Mode 3, width=32, TX 0xDEADBEEF, MOSI 0x12345678 → master reads 0xDEADBEEF; RX equals 0x12345678.
- Mode 1, width=16, three words in one cs frame, TX fed just in time → RX yields 3 words in order; no overrun or underrun.
- Mode 2, width=8, `m_axis_tready` held 0 for two words → the first word is kept, `overrun` pulses once, and the second word is lost.
- Empty holding register at cs fall, mode 0 → MISO all 0 and `underrun` pulses once. cs rises after 5 bits → no `m_axis_tvalid`, and the next frame starts at bit 0.
- Reset pulse mid-word → all outputs return to reset values; the next frame operates normally.
